// File: rtl/nubus_arbiter.sv
// ---------------------------------------------------------------------------
// nubus_arbiter
//
// NuBus distributed-arbitration front end for the test card. When the master
// controller asks for the bus, this block asserts /RQST, drives the slot ID
// onto the open-collector /ARB[3:0] lines using the bit-serial back-off rule,
// waits the settle time, and then raises arb_grant if this card's ID is the
// one left on the bus. It holds the grant through the ownership tenure and
// releases /RQST once the tenure's /START has been seen.
//
// Ports
//   nub_clkn     in   bus clock, all flops on its rising edge
//   nub_reset    in   asynchronous reset, active-high
//   arb_id       in   [3:0] card slot ID (active-high, static after reset)
//   mst_arbcyn   in   master wants the bus (low = arbitrate)
//   mst_ownern   in   master owns the bus (low = owner)
//   mst_lockedn  in   master in a locked sequence (low = locked)
//   nub_arbn_i   in   [3:0] sampled /ARB lines (active-low)
//   nub_startn   in   sampled /START
//   nub_rqstn_i  in   sampled /RQST (status only)
//   nub_arb_oe   out  [3:0] per-bit pull-down enable for /ARB (1 = drive low)
//   nub_rqst_oe  out  pull-down enable for /RQST
//   arb_grant    out  this card won arbitration (registered)
//   arb_busy     out  arbiter not idle
//   arb_losses   out  [LOSS_W-1:0] saturating count of lost arbitrations
// ---------------------------------------------------------------------------
module nubus_arbiter #(
    parameter int SETTLE_CLKS = 2,
    parameter int LOSS_W      = 8
) (
    input  logic              nub_clkn,
    input  logic              nub_reset,
    input  logic [3:0]        arb_id,
    input  logic              mst_arbcyn,
    input  logic              mst_ownern,
    input  logic              mst_lockedn,
    input  logic [3:0]        nub_arbn_i,
    input  logic              nub_startn,
    input  logic              nub_rqstn_i,
    output logic [3:0]        nub_arb_oe,
    output logic              nub_rqst_oe,
    output logic              arb_grant,
    output logic              arb_busy,
    output logic [LOSS_W-1:0] arb_losses
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        WIN  = 2'd2,
        OWN  = 2'd3
    } state_t;

    localparam int                CNT_W    = (SETTLE_CLKS > 1) ? $clog2(SETTLE_CLKS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CLKS - 1);

    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
        return (&v) ? v : v + LOSS_W'(1);
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LOSS_W-1:0]   losses_q, losses_d;
    logic                grant_q;
    logic                start_seen_q, start_seen_d;

    logic [3:0]          bus;
    logic [3:0]          outranked;
    logic                contend;

    // /RQST from other cards is watched by the master controller for
    // fairness; this block has no use for it.
    logic                unused_rqstn;
    assign unused_rqstn = nub_rqstn_i;

    assign bus = ~nub_arbn_i;

    // A bit of the bus is "outranked" when some other card pulls it while
    // our ID has a zero there: every lower bit of ours must then back off.
    assign outranked = bus & ~arb_id;

    assign contend = (state_q == ARB) || (state_q == WIN);

    always_comb begin
        nub_arb_oe[3] = contend & arb_id[3];
        nub_arb_oe[2] = contend & arb_id[2] & ~outranked[3];
        nub_arb_oe[1] = contend & arb_id[1] & ~outranked[3] & ~outranked[2];
        nub_arb_oe[0] = contend & arb_id[0] & ~outranked[3] & ~outranked[2] & ~outranked[1];
    end

    // /RQST stays asserted into the tenure until /START has been sampled,
    // after which later requesters may queue behind us.
    assign nub_rqst_oe = contend || ((state_q == OWN) && !start_seen_q);
    assign arb_busy    = (state_q != IDLE);
    assign arb_grant   = grant_q;
    assign arb_losses  = losses_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        losses_d     = losses_q;
        start_seen_d = start_seen_q;
        case (state_q)
            IDLE: begin
                cnt_d        = '0;
                start_seen_d = 1'b0;
                if (!mst_arbcyn) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (mst_arbcyn) begin
                    // Master withdrew: abandon without counting a loss.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // End of settle window: the bus now holds the winner's ID.
                    cnt_d = '0;
                    if (bus == arb_id) begin
                        state_d = WIN;
                    end else begin
                        losses_d = sat_inc(losses_q);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WIN: begin
                // Ownership takes precedence over a simultaneous withdrawal.
                if (!mst_ownern) begin
                    state_d      = OWN;
                    start_seen_d = 1'b0;
                end else if (mst_arbcyn) begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (!nub_startn) begin
                    start_seen_d = 1'b1;
                end
                if (mst_ownern && mst_lockedn) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge nub_clkn or posedge nub_reset) begin
        if (nub_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            losses_q     <= '0;
            grant_q      <= 1'b0;
            start_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            losses_q     <= losses_d;
            grant_q      <= (state_d == WIN) || (state_d == OWN);
            start_seen_q <= start_seen_d;
        end
    end

endmodule

// File: tb/tb_nubus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nubus_arbiter
//
// Bench for nubus_arbiter. The /ARB bus is modelled as a wired-OR of this
// card's pull-downs and one other card that follows the same back-off rule;
// the pads re-sample the bus on every falling clock edge. A behavioural
// model of the arbitration protocol predicts every output each cycle, and
// directed scenarios add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_nubus_arbiter;

    localparam int SETTLE   = 2;
    localparam int LW       = 8;
    localparam int LOSS_MAX = (1 << LW) - 1;

    logic          nub_clkn;
    logic          nub_reset;
    logic [3:0]    arb_id;
    logic          mst_arbcyn;
    logic          mst_ownern;
    logic          mst_lockedn;
    logic [3:0]    nub_arbn_i;
    logic          nub_startn;
    logic          nub_rqstn_i;
    logic [3:0]    nub_arb_oe;
    logic          nub_rqst_oe;
    logic          arb_grant;
    logic          arb_busy;
    logic [LW-1:0] arb_losses;

    nubus_arbiter #(
        .SETTLE_CLKS (SETTLE),
        .LOSS_W      (LW)
    ) dut (
        .nub_clkn    (nub_clkn),
        .nub_reset   (nub_reset),
        .arb_id      (arb_id),
        .mst_arbcyn  (mst_arbcyn),
        .mst_ownern  (mst_ownern),
        .mst_lockedn (mst_lockedn),
        .nub_arbn_i  (nub_arbn_i),
        .nub_startn  (nub_startn),
        .nub_rqstn_i (nub_rqstn_i),
        .nub_arb_oe  (nub_arb_oe),
        .nub_rqst_oe (nub_rqst_oe),
        .arb_grant   (arb_grant),
        .arb_busy    (arb_busy),
        .arb_losses  (arb_losses)
    );

    initial nub_clkn = 1'b0;
    always #5 nub_clkn = ~nub_clkn;

    // Winner rule: a card keeps only the ID bits above the highest position
    // where the bus carries a 1 that its own ID lacks.
    function automatic logic [3:0] exp_drive(input logic [3:0] id, input logic [3:0] bus);
        logic [3:0] beaten;
        logic [4:0] keep;
        int         top;
        beaten = bus & ~id;
        top    = -1;
        for (int k = 0; k < 4; k++) begin
            if (beaten[k]) top = k;
        end
        if (top < 0) return id;
        keep = 5'h1F << (top + 1);
        return id & keep[3:0];
    endfunction

    // Wired-OR bus and the other card.
    logic       other_active;
    logic [3:0] other_id;
    logic [3:0] other_oe;
    logic [3:0] bus_q = 4'h0;

    assign other_oe   = other_active ? exp_drive(other_id, bus_q) : 4'h0;
    assign nub_arbn_i = ~bus_q;

    always @(negedge nub_clkn) begin
        bus_q <= nub_arb_oe | other_oe;
    end

    // Bookkeeping
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural protocol model
    bit m_contend, m_won, m_owner, m_start_seen;
    int m_wstart;
    int m_losses;

    task automatic model_reset();
        m_contend    = 1'b0;
        m_won        = 1'b0;
        m_owner      = 1'b0;
        m_start_seen = 1'b0;
        m_wstart     = 0;
        m_losses     = 0;
    endtask

    // Applied at each rising edge with the values the DUT samples there.
    task automatic model_step();
        if (nub_reset) begin
            model_reset();
            return;
        end
        if (m_owner) begin
            if (!nub_startn) m_start_seen = 1'b1;
            if (mst_ownern && mst_lockedn) begin
                m_owner      = 1'b0;
                m_start_seen = 1'b0;
            end
        end else if (m_won) begin
            if (!mst_ownern) begin
                m_won        = 1'b0;
                m_owner      = 1'b1;
                m_start_seen = 1'b0;
            end else if (mst_arbcyn) begin
                m_won = 1'b0;
            end
        end else if (m_contend) begin
            if (mst_arbcyn) begin
                m_contend = 1'b0;
            end else if (cyc - m_wstart == SETTLE) begin
                if (bus_q == arb_id) begin
                    m_contend = 1'b0;
                    m_won     = 1'b1;
                end else begin
                    if (m_losses < LOSS_MAX) m_losses++;
                    m_wstart = cyc;
                end
            end
        end else if (!mst_arbcyn) begin
            m_contend = 1'b1;
            m_wstart  = cyc;
        end
    endtask

    task automatic compare_all();
        logic [3:0] e_oe;
        e_oe = (m_contend || m_won) ? exp_drive(arb_id, bus_q) : 4'h0;
        check("arb_oe",   nub_arb_oe,  e_oe);
        check("rqst_oe",  nub_rqst_oe, m_contend || m_won || (m_owner && !m_start_seen));
        check("grant",    arb_grant,   m_won || m_owner);
        check("busy",     arb_busy,    m_contend || m_won || m_owner);
        check("losses",   arb_losses,  m_losses);
    endtask

    // One clock: model the edge, compare just after it, return at edge+2
    // where the caller drives the next inputs.
    task automatic cycle();
        @(posedge nub_clkn);
        cyc++;
        model_step();
        #1;
        compare_all();
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input logic [3:0] id);
        nub_reset = 1'b1;
        #1;
        check("rst_grant",  arb_grant,   1'b0);
        check("rst_busy",   arb_busy,    1'b0);
        check("rst_rqst",   nub_rqst_oe, 1'b0);
        check("rst_arb_oe", nub_arb_oe,  4'h0);
        check("rst_losses", arb_losses,  0);
        model_reset();
        arb_id = id;
        cycle();
        nub_reset = 1'b0;
    endtask

    task automatic wait_grant(input int budget);
        int n;
        n = 0;
        while (!arb_grant && n < budget) begin
            cycle();
            n++;
        end
        check("grant_wait", arb_grant, 1'b1);
    endtask

    initial begin
        nub_reset    = 1'b1;
        arb_id       = 4'hA;
        mst_arbcyn   = 1'b1;
        mst_ownern   = 1'b1;
        mst_lockedn  = 1'b1;
        nub_startn   = 1'b1;
        nub_rqstn_i  = 1'b1;
        other_active = 1'b0;
        other_id     = 4'h0;
        model_reset();
        #1;
        do_reset(4'hA);
        cycles(2);

        // Uncontested, ID A
        mst_arbcyn = 1'b0;
        cycle();
        check("unc_oe_clk1", nub_arb_oe, 4'hA);
        check("unc_rqst_clk1", nub_rqst_oe, 1'b1);
        cycle();
        check("unc_nogrant_clk2", arb_grant, 1'b0);
        cycle();
        check("unc_grant_clk3", arb_grant, 1'b1);
        mst_arbcyn = 1'b1;
        cycle();
        check("unc_abort_win", arb_grant, 1'b0);

        // Contested loss: ID 5 joined by another card at C
        do_reset(4'h5);
        cycles(2);
        other_id   = 4'hC;
        mst_arbcyn = 1'b0;
        cycle();
        check("loss_oe_alone", nub_arb_oe, 4'h5);
        other_active = 1'b1;
        cycle();
        check("loss_oe_collapse", nub_arb_oe, 4'h0);
        cycle();
        check("loss_first", arb_losses, 1);
        check("loss_nogrant", arb_grant, 1'b0);
        cycles(2);
        check("loss_second", arb_losses, 2);

        // Abort in ARB just before a compare
        cycle();
        mst_arbcyn = 1'b1;
        cycle();
        check("abort_idle", arb_busy, 1'b0);
        check("abort_noloss", arb_losses, 2);

        // Win on an empty bus, own, then reset mid-tenure
        other_active = 1'b0;
        cycles(2);
        mst_arbcyn = 1'b0;
        wait_grant(10);
        mst_ownern = 1'b0;
        mst_arbcyn = 1'b1;
        cycle();
        check("own_oe_off", nub_arb_oe, 4'h0);
        #2;
        do_reset(4'hE);
        mst_ownern = 1'b1;
        cycles(2);

        // Contested win: E against 7
        other_id     = 4'h7;
        other_active = 1'b1;
        mst_arbcyn   = 1'b0;
        cycle();
        cycle();
        check("win_bus_both", bus_q, 4'hF);
        cycle();
        check("win_grant", arb_grant, 1'b1);
        check("win_losses", arb_losses, 0);
        check("win_bus_settled", bus_q, 4'hE);

        // Ownership and release
        mst_ownern = 1'b0;
        mst_arbcyn = 1'b1;
        other_active = 1'b0;
        cycle();
        check("own_oe", nub_arb_oe, 4'h0);
        check("own_rqst_held", nub_rqst_oe, 1'b1);
        nub_startn = 1'b0;
        cycle();
        check("own_rqst_rel", nub_rqst_oe, 1'b0);
        nub_startn = 1'b1;
        mst_ownern = 1'b1;
        cycle();
        check("rel_grant", arb_grant, 1'b0);
        check("rel_busy", arb_busy, 1'b0);

        // Locked hold
        mst_arbcyn = 1'b0;
        wait_grant(10);
        mst_arbcyn  = 1'b1;
        mst_ownern  = 1'b0;
        mst_lockedn = 1'b0;
        cycle();
        mst_ownern = 1'b1;
        cycles(3);
        check("lock_grant", arb_grant, 1'b1);
        check("lock_busy", arb_busy, 1'b1);
        mst_lockedn = 1'b1;
        cycle();
        check("lock_rel", arb_busy, 1'b0);

        // ID 0: wins an empty bus, loses to anyone
        do_reset(4'h0);
        cycles(2);
        mst_arbcyn = 1'b0;
        cycles(3);
        check("id0_empty_win", arb_grant, 1'b1);
        mst_arbcyn = 1'b1;
        cycle();
        other_id     = 4'h1;
        other_active = 1'b1;
        cycles(2);
        mst_arbcyn = 1'b0;
        cycles(3);
        check("id0_lose", arb_grant, 1'b0);
        check("id0_loss_cnt", arb_losses, 1);
        mst_arbcyn = 1'b1;
        cycle();

        // Loss counter saturation
        do_reset(4'h5);
        other_id     = 4'hC;
        other_active = 1'b1;
        cycles(2);
        mst_arbcyn = 1'b0;
        cycles(2 * (LOSS_MAX + 6));
        check("loss_saturate", arb_losses, LOSS_MAX);
        mst_arbcyn   = 1'b1;
        other_active = 1'b0;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset(4'($urandom_range(0, 15)));
            end else begin
                if ($urandom_range(0, 7) == 0) mst_arbcyn = ~mst_arbcyn;
                mst_ownern  = ($urandom_range(0, 3) != 0);
                mst_lockedn = ($urandom_range(0, 5) != 0);
                nub_startn  = ($urandom_range(0, 2) != 0);
                nub_rqstn_i = ($urandom_range(0, 1) != 0);
                if ($urandom_range(0, 9) == 0) other_active = ~other_active;
                if ($urandom_range(0, 19) == 0) other_id = 4'($urandom_range(0, 15));
                cycle();
            end
        end

        // Asynchronous reset in the middle of a cycle
        #2;
        do_reset(4'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nubus_arbiter.md
Name: nubus_arbiter

Overview:
- NuBus distributed-arbitration front end for the test card.
- Asserts /RQST and drives the slot ID onto the open-collector /ARB[3:0] lines using the standard bit-serial back-off rule.
- Counts the mandatory settle time and raises arb_grant to the master controller when this card has won.
- Sits between the bus pads and the master controller: consumes its arbitration-cycle and owner strobes, and returns grant and status.

Parameters:
- SETTLE_CLKS, 2, clocks /ARB must be driven before the winner comparison is registered (minimum 1).
- LOSS_W, 8, width of the saturating lost-arbitration counter.

Ports:
- nub_clkn  in  1  bus clock; all flops on its rising edge.
- nub_reset  in  1  asynchronous reset, active-high.
- arb_id  in  4  card slot ID, active-high, static after reset.
- mst_arbcyn  in  1  master wants the bus (low = arbitrate).
- mst_ownern  in  1  master owns the bus (low = owner).
- mst_lockedn  in  1  master in a locked sequence (low = locked).
- nub_arbn_i  in  4  sampled /ARB bus lines, active-low.
- nub_startn  in  1  sampled /START.
- nub_rqstn_i  in  1  sampled /RQST.
- nub_arb_oe  out  4  per-bit pull-down enable for /ARB (1 = drive low).
- nub_rqst_oe  out  1  pull-down enable for /RQST.
- arb_grant  out  1  this card won arbitration (registered).
- arb_busy  out  1  arbiter not IDLE.
- arb_losses  out  LOSS_W  saturating count of lost arbitrations since reset.

Behaviour:
- bus[3:0] = ~nub_arbn_i.
- Drive rule, combinational from bus and arb_id, gated by contend:
  - nub_arb_oe[k] = contend & arb_id[k] & AND over j>k of ~(bus[j] & ~arb_id[j]).
  - Result: bit 3 is driven whenever arb_id[3]=1 and contend=1.
- contend = 1 in ARB and WIN states only.
- nub_rqst_oe = 1 in ARB and WIN.
- States and transitions:
  - IDLE: all outputs 0.
    - -> ARB when mst_arbcyn=0.
    - Settle counter cleared.
  - ARB: counter increments each clock.
    - When counter reaches SETTLE_CLKS-1, compare registered bus==arb_id.
    - Equal: -> WIN, arb_grant <= 1.
    - Unequal: arb_losses += 1 (saturate at all-ones); counter cleared; stay in ARB and recontend.
    - mst_arbcyn=1 at any point in ARB: -> IDLE, no loss counted.
  - WIN: arb_grant=1, /ARB and /RQST still driven.
    - -> OWN on first clock with mst_ownern=0.
    - mst_arbcyn=1 before ownership: -> IDLE, grant dropped.
  - OWN: arb_grant=1, nub_arb_oe=0.
    - nub_rqst_oe is released in the clock nub_startn=0 is sampled. Other requesters may then arbitrate behind this tenure.
    - -> IDLE when mst_ownern=1 and mst_lockedn=1.
    - While mst_lockedn=0, stay in OWN regardless of mst_ownern.
- Latency: mst_arbcyn low to arb_grant high = SETTLE_CLKS+1 clocks when uncontested.
- arb_busy = (state != IDLE).
- mst_arbcyn high and mst_ownern low in the same clock in WIN: ownership wins -> OWN.
- Reset mid-operation: all outputs 0 immediately (asynchronous); arb_losses cleared; state IDLE.
- arb_id = 0: card can never win against any other contender. It still wins an empty bus (bus==0==arb_id).
- nub_rqstn_i is status only. Fairness gating (no new request while /RQST is held by others) stays in the master controller.

Test Plan:
- Uncontested: arb_id=4'hA, mst_arbcyn low at clk0, other cards drive nothing
  -> nub_arb_oe=4'hA at clk1, arb_grant=1 at clk SETTLE_CLKS+1 (clk3 at default).
- Contested loss: arb_id=4'h5, bench ORs in 4'hC from another card
  -> nub_arb_oe collapses to 4'h0 within the same cycle; no grant; arb_losses=1 after the first compare and increments each window.
- Contested win: arb_id=4'hE vs other 4'h7 (bus=4'hF initially)
  -> the other card backs off, bus settles to 4'hE, arb_grant=1, arb_losses=0.
- Ownership and release:
  - Win, then mst_ownern=0 -> nub_arb_oe=0 next clock.
  - nub_startn=0 -> nub_rqst_oe=0 next clock.
  - mst_ownern=1 -> IDLE, arb_grant=0.
- Locked hold: mst_lockedn=0 while mst_ownern toggles high
  -> state stays OWN, arb_grant=1; returns to IDLE only after mst_lockedn=1.
- Abort and reset:
  - mst_arbcyn=1 in ARB -> IDLE with no loss counted.
  - nub_reset pulsed during OWN -> all outputs 0 asynchronously; arb_losses=0.
